// File: rtl/gen_trafico_pkg.sv
// rtl/gen_trafico_pkg.sv - shared state encoding, pattern modes and LFSR taps for gen_trafico
package gen_trafico_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        BURST = 3'd2,
        GAP   = 3'd3,
        FIN   = 3'd4
    } stateT;

    localparam logic [1:0] MODE_FIXED = 2'd0;
    localparam logic [1:0] MODE_INCR  = 2'd1;
    localparam logic [1:0] MODE_LFSR  = 2'd2;
    localparam logic [1:0] MODE_WALK  = 2'd3;

    // Maximal-length Fibonacci tap masks; bit n-1 set for polynomial term x^n.
    function automatic logic [31:0] lfsrTaps(input int width);
        case (width)
            4:       return 32'h0000000C;
            5:       return 32'h00000014;
            6:       return 32'h00000030;
            7:       return 32'h00000060;
            8:       return 32'h000000B8;
            9:       return 32'h00000110;
            10:      return 32'h00000240;
            11:      return 32'h00000500;
            12:      return 32'h00000829;
            13:      return 32'h0000100D;
            14:      return 32'h00002015;
            15:      return 32'h00006000;
            16:      return 32'h0000D008;
            17:      return 32'h00012000;
            18:      return 32'h00020400;
            19:      return 32'h00040023;
            20:      return 32'h00090000;
            21:      return 32'h00140000;
            22:      return 32'h00300000;
            23:      return 32'h00420000;
            24:      return 32'h00E10000;
            25:      return 32'h01200000;
            26:      return 32'h02000023;
            27:      return 32'h04000013;
            28:      return 32'h09000000;
            29:      return 32'h14000000;
            30:      return 32'h20000029;
            31:      return 32'h48000000;
            32:      return 32'h80200003;
            default: return 32'h0000000C;
        endcase
    endfunction

endpackage

// File: rtl/gen_lane.sv
// rtl/gen_lane.sv - one output lane: loads its seed and steps its pattern on each accepted beat
module gen_lane
    import gen_trafico_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_1,
    input  logic             reset,
    input  logic             load,
    input  logic             advance,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] value
);

    localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsrTaps(WIDTH));

    logic [WIDTH-1:0] nextValue;

    always_comb begin
        nextValue = value;
        case (mode)
            MODE_FIXED: nextValue = value;
            MODE_INCR:  nextValue = value + {{(WIDTH-1){1'b0}}, 1'b1};
            MODE_LFSR:  nextValue = {value[WIDTH-2:0], ^(value & TAPS)};
            MODE_WALK:  nextValue = {value[WIDTH-2:0], value[WIDTH-1]};
            default:    nextValue = value;
        endcase
    end

    always_ff @(posedge clk_1 or negedge reset) begin
        if (!reset) begin
            value <= '0;
        end else if (load) begin
            // An all-zero LFSR would never leave zero.
            if (mode == MODE_LFSR && seed == '0)
                value <= {{(WIDTH-1){1'b0}}, 1'b1};
            else
                value <= seed;
        end else if (advance) begin
            value <= nextValue;
        end
    end

endmodule

// File: rtl/gen_trafico.sv
// rtl/gen_trafico.sv - burst traffic generator: sequencing FSM, counters and LANES pattern lanes
module gen_trafico
    import gen_trafico_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LANES = 2,
    parameter int BLW   = 5
) (
    input  logic                   clk_1,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic [1:0]             mode,
    input  logic [WIDTH-1:0]       seed,
    input  logic [BLW-1:0]         burst_len,
    input  logic [3:0]             gap_len,
    input  logic [3:0]             num_bursts,
    input  logic [LANES-1:0]       ready,
    output logic [LANES*WIDTH-1:0] data_out,
    output logic [LANES-1:0]       valid_out,
    output logic                   selector,
    output logic                   busy,
    output logic                   done,
    output logic [15:0]            beat_count
);

    stateT            state;
    logic [1:0]       cfgMode;
    logic [WIDTH-1:0] cfgSeed;
    logic [BLW-1:0]   cfgBurstLen;
    logic [BLW-1:0]   beatInBurst;
    logic [3:0]       cfgGapLen;
    logic [3:0]       cfgNumBursts;
    logic [3:0]       burstIdx;
    logic [3:0]       gapCnt;
    logic             accept;
    logic             lastBeat;
    logic             lastBurst;
    logic             laneLoad;

    assign accept    = (&valid_out) & (&ready);
    assign lastBeat  = accept && (beatInBurst == cfgBurstLen - BLW'(1));
    assign lastBurst = (burstIdx == cfgNumBursts - 4'd1);
    assign laneLoad  = (state == LOAD);

    always_ff @(posedge clk_1 or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cfgMode      <= MODE_FIXED;
            cfgSeed      <= '0;
            cfgBurstLen  <= '0;
            cfgGapLen    <= '0;
            cfgNumBursts <= '0;
            beatInBurst  <= '0;
            burstIdx     <= '0;
            gapCnt       <= '0;
            valid_out    <= '0;
            selector     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            beat_count   <= '0;
        end else begin
            done <= 1'b0;
            if (accept && beat_count != 16'hFFFF)
                beat_count <= beat_count + 16'd1;

            case (state)
                IDLE: begin
                    if (start) begin
                        cfgMode      <= mode;
                        cfgSeed      <= seed;
                        cfgBurstLen  <= burst_len;
                        cfgGapLen    <= gap_len;
                        cfgNumBursts <= num_bursts;
                        busy         <= 1'b1;
                        state        <= LOAD;
                    end
                end
                LOAD: begin
                    beat_count  <= '0;
                    selector    <= 1'b0;
                    beatInBurst <= '0;
                    burstIdx    <= '0;
                    if (abort || cfgBurstLen == '0 || cfgNumBursts == 4'd0) begin
                        done  <= 1'b1;
                        state <= FIN;
                    end else begin
                        valid_out <= '1;
                        state     <= BURST;
                    end
                end
                BURST: begin
                    if (accept)
                        beatInBurst <= beatInBurst + BLW'(1);
                    if (lastBeat) begin
                        selector    <= ~selector;
                        beatInBurst <= '0;
                        burstIdx    <= burstIdx + 4'd1;
                    end
                    // The beat accepted alongside an abort still counts above.
                    if ((lastBeat && lastBurst) || abort) begin
                        valid_out <= '0;
                        done      <= 1'b1;
                        state     <= FIN;
                    end else if (lastBeat && cfgGapLen != 4'd0) begin
                        valid_out <= '0;
                        gapCnt    <= cfgGapLen;
                        state     <= GAP;
                    end
                end
                GAP: begin
                    if (abort) begin
                        done  <= 1'b1;
                        state <= FIN;
                    end else if (gapCnt == 4'd1) begin
                        valid_out <= '1;
                        state     <= BURST;
                    end else begin
                        gapCnt <= gapCnt - 4'd1;
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : gLane
        gen_lane #(.WIDTH(WIDTH)) uLane (
            .clk_1   (clk_1),
            .reset   (reset),
            .load    (laneLoad),
            .advance (accept),
            .mode    (cfgMode),
            .seed    (cfgSeed ^ WIDTH'(i)),
            .value   (data_out[i*WIDTH +: WIDTH])
        );
    end

endmodule

// File: doc/gen_trafico.md
GEN_TRAFICO -- requirements
Module: gen_trafico

Interface
REQ-001 Parameter WIDTH, default 8, data width per lane in bits (range 4..32).
REQ-002 Parameter LANES, default 2, number of independent output lanes (range 1..8).
REQ-003 Parameter BLW, default 5, width of the burst_len input.
REQ-004 Port clk_1  input  1  single clock; all state updates on its rising edge.
REQ-005 Port reset  input  1  asynchronous, active-low reset.
REQ-006 Port start  input  1  one-cycle request to begin a sequence.
REQ-007 Port abort  input  1  synchronous request to end a sequence immediately.
REQ-008 Port mode  input  2  pattern: 0 fixed, 1 incrementing, 2 LFSR, 3 walking-one; sampled on start.
REQ-009 Port seed  input  WIDTH  initial pattern value; sampled on start.
REQ-010 Port burst_len  input  BLW  beats per burst; sampled on start.
REQ-011 Port gap_len  input  4  idle cycles between bursts; sampled on start.
REQ-012 Port num_bursts  input  4  bursts per sequence; sampled on start.
REQ-013 Port ready  input  LANES  per-lane sink ready.
REQ-014 Port data_out  output  LANES*WIDTH  lane i occupies bits [i*WIDTH +: WIDTH].
REQ-015 Port valid_out  output  LANES  per-lane valid.
REQ-016 Port selector  output  1  routing select for the downstream block.
REQ-017 Port busy  output  1  high outside IDLE.
REQ-018 Port done  output  1  one-cycle pulse at sequence end.
REQ-019 Port beat_count  output  16  accepted beats in the current sequence, saturating at 16'hFFFF.

Function
REQ-020 The FSM SHALL have the states IDLE, LOAD, BURST, GAP and FIN.
- IDLE->LOAD on start; start is ignored in every other state.
- LOAD lasts 1 cycle, latches the configuration and clears beat_count.
REQ-021 A beat SHALL be accepted only when valid_out is all-ones and ready is all-ones; lanes advance in lockstep.
- While not accepted, data_out and valid_out hold stable.
REQ-022 In BURST, valid_out SHALL be all-ones; a burst ends on the accepted beat number burst_len.
REQ-023 After a burst that is not the last one:
- go to GAP for gap_len cycles, with valid_out=0;
- if gap_len=0, go BURST->BURST directly with no idle cycle.
REQ-024 After the accepted beat of burst num_bursts, the FSM SHALL go to FIN.
- FIN lasts 1 cycle and asserts done; the FSM then returns to IDLE.
REQ-025 selector SHALL toggle on the cycle after each completed burst; it is cleared in LOAD.
REQ-026 Lane data on the first beat SHALL be seed ^ i for lane i; on each accepted beat the value updates per mode:
- mode 0: the value holds.
- mode 1: the value increments modulo 2^WIDTH (wraps to 0).
- mode 2: Fibonacci LFSR per lane, taps from the shared package.
- mode 3: rotate left by one.
REQ-027 In mode 2, a lane value of 0 SHALL be replaced by 1 at load so the LFSR cannot lock up.
REQ-028 burst_len=0 or num_bursts=0 SHALL produce LOAD->FIN with no beats; done still pulses.
REQ-029 abort in any non-IDLE state SHALL take effect on the next edge:
- valid_out=0, the FSM goes to FIN, done pulses;
- beat_count keeps its value.
REQ-030 If abort and the final accepted beat fall in the same cycle, the beat SHALL count and done SHALL pulse once.
REQ-031 An accept latency of zero cycles SHALL hold: a beat accepted at edge k presents the next data at edge k.

Reset
REQ-032 Asserting reset (low) SHALL asynchronously force:
- state IDLE;
- data_out, valid_out, selector, busy, done and beat_count all 0.
REQ-033 Reset mid-burst SHALL discard the sequence; after release the block waits for a new start.
REQ-034 Deassertion of reset is synchronised externally; the block needs no first-cycle special case.

Structure
REQ-035 A shared package gen_trafico_pkg SHALL hold:
- the state encoding;
- the mode constants;
- per-WIDTH LFSR tap constants.
REQ-036 Per-lane pattern generation SHALL be one sub-module, gen_lane, instantiated LANES times; the FSM and counters stay in gen_trafico.

Verification
REQ-037 WIDTH=8, LANES=2, mode 1, seed 8'hFE, burst_len 3, gap 2, num_bursts 1, ready=11 -> lane0 FE,FF,00; lane1 FF,00,01; done pulses; beat_count 3.
REQ-038 mode 0, burst_len 4, num_bursts 2, gap 0, ready=11 -> 8 contiguous valid beats; selector toggles after beats 4 and 8.
REQ-039 ready=01 for 3 cycles mid-burst -> data_out and valid_out held stable; beat_count does not advance.
REQ-040 num_bursts=0 with start -> valid_out never asserts; done pulses 2 cycles after start.
REQ-041 abort during GAP -> FIN, done pulses once, beat_count retained; a following start is accepted.
REQ-042 reset low mid-burst -> all outputs 0 immediately; mode 2 with seed 0 after restart -> lane0 first beat 1.
